// File: rtl/speech_sequencer.sv
// Speech-recognition control sequencer: captures audio bytes into template or
// live memory regions and schedules the comparison engine over trained slots.
module speech_sequencer #(
    parameter int          IDX_W        = 8,
    parameter int          NSLOT        = 4,
    parameter logic [15:0] MATCH_THRESH = 16'd4000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_valid,
    input  logic [7:0]       sample,
    input  logic             train_start,
    input  logic [2:0]       train_slot,
    input  logic             recog_start,
    input  logic             abort,
    output logic             mem_we,
    output logic [2:0]       mem_region,
    output logic [IDX_W-1:0] mem_idx,
    output logic [7:0]       mem_wdata,
    output logic             cmp_start,
    output logic [2:0]       cmp_slot,
    input  logic             cmp_done,
    input  logic [15:0]      cmp_score,
    output logic             busy,
    output logic [NSLOT-1:0] slot_valid,
    output logic             train_done,
    output logic             result_valid,
    output logic [2:0]       result_slot,
    output logic [15:0]      result_score,
    output logic             no_match,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CAPTURE   = 3'd1,
        CMP_ISSUE = 3'd2,
        CMP_WAIT  = 3'd3,
        REPORT    = 3'd4
    } state_e;

    localparam logic [2:0]       NSLOT_L  = 3'(NSLOT);
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    state_e             state_q, state_d;
    logic [2:0]         region_q, region_d;
    logic               train_q, train_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NSLOT-1:0]   sv_q, sv_d;
    logic [2:0]         cand_q, cand_d;
    logic [15:0]        best_score_q, best_score_d;
    logic [2:0]         best_slot_q, best_slot_d;
    logic               we_q, we_d;
    logic [2:0]         mreg_q, mreg_d;
    logic [IDX_W-1:0]   midx_q, midx_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               cstart_q, cstart_d;
    logic               tdone_q, tdone_d;
    logic               rvalid_q, rvalid_d;
    logic [2:0]         rslot_q, rslot_d;
    logic [15:0]        rscore_q, rscore_d;
    logic               nm_q, nm_d;

    logic               low_found, nxt_found;
    logic [2:0]         low_slot, nxt_slot;

    always_comb begin
        low_found = 1'b0;
        low_slot  = 3'd0;
        nxt_found = 1'b0;
        nxt_slot  = 3'd0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!low_found && sv_q[i]) begin
                low_found = 1'b1;
                low_slot  = 3'(i);
            end
            if (!nxt_found && sv_q[i] && 3'(i) > cand_q) begin
                nxt_found = 1'b1;
                nxt_slot  = 3'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        region_d     = region_q;
        train_d      = train_q;
        idx_d        = idx_q;
        sv_d         = sv_q;
        cand_d       = cand_q;
        best_score_d = best_score_q;
        best_slot_d  = best_slot_q;
        we_d         = 1'b0;
        mreg_d       = mreg_q;
        midx_d       = midx_q;
        wdata_d      = wdata_q;
        cstart_d     = 1'b0;
        tdone_d      = 1'b0;
        rvalid_d     = 1'b0;
        rslot_d      = rslot_q;
        rscore_d     = rscore_q;
        nm_d         = nm_q;
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (train_start && train_slot < NSLOT_L) begin
                        region_d = train_slot;
                        train_d  = 1'b1;
                        idx_d    = '0;
                        for (int i = 0; i < NSLOT; i++)
                            if (train_slot == 3'(i)) sv_d[i] = 1'b0;
                        state_d  = CAPTURE;
                    end else if (recog_start) begin
                        region_d = NSLOT_L;
                        train_d  = 1'b0;
                        idx_d    = '0;
                        state_d  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        we_d    = 1'b1;
                        mreg_d  = region_q;
                        midx_d  = idx_q;
                        wdata_d = sample;
                        idx_d   = idx_q + IDX_ONE;
                        if (idx_q == IDX_LAST) begin
                            if (train_q) begin
                                for (int i = 0; i < NSLOT; i++)
                                    if (region_q == 3'(i)) sv_d[i] = 1'b1;
                                tdone_d = 1'b1;
                                state_d = IDLE;
                            end else begin
                                best_score_d = 16'hFFFF;
                                best_slot_d  = 3'd0;
                                cand_d       = low_slot;
                                state_d      = low_found ? CMP_ISSUE : REPORT;
                            end
                        end
                    end
                end
                CMP_ISSUE: begin
                    cstart_d = 1'b1;
                    state_d  = CMP_WAIT;
                end
                CMP_WAIT: begin
                    if (cmp_done) begin
                        if (cmp_score < best_score_q) begin
                            best_score_d = cmp_score;
                            best_slot_d  = cand_q;
                        end
                        // Invalid slots are skipped by jumping straight to the next valid one
                        if (nxt_found) begin
                            cand_d  = nxt_slot;
                            state_d = CMP_ISSUE;
                        end else begin
                            state_d = REPORT;
                        end
                    end
                end
                REPORT: begin
                    rvalid_d = 1'b1;
                    rslot_d  = best_slot_q;
                    rscore_d = best_score_q;
                    nm_d     = best_score_q > MATCH_THRESH;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            region_q     <= 3'd0;
            train_q      <= 1'b0;
            idx_q        <= '0;
            sv_q         <= '0;
            cand_q       <= 3'd0;
            best_score_q <= 16'd0;
            best_slot_q  <= 3'd0;
            we_q         <= 1'b0;
            mreg_q       <= 3'd0;
            midx_q       <= '0;
            wdata_q      <= 8'd0;
            cstart_q     <= 1'b0;
            tdone_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rslot_q      <= 3'd0;
            rscore_q     <= 16'd0;
            nm_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            region_q     <= region_d;
            train_q      <= train_d;
            idx_q        <= idx_d;
            sv_q         <= sv_d;
            cand_q       <= cand_d;
            best_score_q <= best_score_d;
            best_slot_q  <= best_slot_d;
            we_q         <= we_d;
            mreg_q       <= mreg_d;
            midx_q       <= midx_d;
            wdata_q      <= wdata_d;
            cstart_q     <= cstart_d;
            tdone_q      <= tdone_d;
            rvalid_q     <= rvalid_d;
            rslot_q      <= rslot_d;
            rscore_q     <= rscore_d;
            nm_q         <= nm_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_region   = mreg_q;
    assign mem_idx      = midx_q;
    assign mem_wdata    = wdata_q;
    assign cmp_start    = cstart_q;
    assign cmp_slot     = cand_q;
    assign busy         = state_q != IDLE;
    assign slot_valid   = sv_q;
    assign train_done   = tdone_q;
    assign result_valid = rvalid_q;
    assign result_slot  = rslot_q;
    assign result_score = rscore_q;
    assign no_match     = nm_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_speech_sequencer.sv
// Directed bench for speech_sequencer with 4-sample utterances and 4 slots.
module tb_speech_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [7:0]  sample;
    logic        train_start;
    logic [2:0]  train_slot;
    logic        recog_start;
    logic        abort;
    logic        mem_we;
    logic [2:0]  mem_region;
    logic [1:0]  mem_idx;
    logic [7:0]  mem_wdata;
    logic        cmp_start;
    logic [2:0]  cmp_slot;
    logic        cmp_done;
    logic [15:0] cmp_score;
    logic        busy;
    logic [3:0]  slot_valid;
    logic        train_done;
    logic        result_valid;
    logic [2:0]  result_slot;
    logic [15:0] result_score;
    logic        no_match;
    logic [2:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    speech_sequencer #(.IDX_W(2), .NSLOT(4), .MATCH_THRESH(16'd4000)) dut (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample(sample),
        .train_start(train_start), .train_slot(train_slot),
        .recog_start(recog_start), .abort(abort),
        .mem_we(mem_we), .mem_region(mem_region), .mem_idx(mem_idx),
        .mem_wdata(mem_wdata), .cmp_start(cmp_start), .cmp_slot(cmp_slot),
        .cmp_done(cmp_done), .cmp_score(cmp_score), .busy(busy),
        .slot_valid(slot_valid), .train_done(train_done),
        .result_valid(result_valid), .result_slot(result_slot),
        .result_score(result_score), .no_match(no_match),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic train(input logic [2:0] slot, input logic [7:0] base,
                         input logic [3:0] exp_sv);
        train_start = 1'b1;
        train_slot  = slot;
        step();
        train_start = 1'b0;
        check("train_state", 32'(state_dbg), 32'd1);
        for (int k = 0; k < 4; k++) begin
            sample_valid = 1'b1;
            sample       = base + 8'(k);
            step();
            sample_valid = 1'b0;
            check("tr_we", 32'(mem_we), 32'd1);
            check("tr_region", 32'(mem_region), 32'(slot));
            check("tr_idx", 32'(mem_idx), 32'(k));
            check("tr_wdata", 32'(mem_wdata), 32'(base + 8'(k)));
            check("tr_done", 32'(train_done), (k == 3) ? 32'd1 : 32'd0);
        end
        check("tr_busy", 32'(busy), 32'd0);
        check("tr_sv", 32'(slot_valid), 32'(exp_sv));
        step();
        check("tr_done_clr", 32'(train_done), 32'd0);
    endtask

    task automatic recog(input int n, input logic [11:0] sl,
                         input logic [63:0] sc, input logic [2:0] es,
                         input logic [15:0] escore, input logic enm);
        recog_start = 1'b1;
        step();
        recog_start = 1'b0;
        check("rc_state", 32'(state_dbg), 32'd1);
        for (int k = 0; k < 4; k++) begin
            sample_valid = 1'b1;
            sample       = 8'hA0 + 8'(k);
            step();
            sample_valid = 1'b0;
            check("rc_we", 32'(mem_we), 32'd1);
            check("rc_region", 32'(mem_region), 32'd4);
            check("rc_idx", 32'(mem_idx), 32'(k));
        end
        check("rc_after_cap", 32'(state_dbg), (n > 0) ? 32'd2 : 32'd4);
        for (int j = 0; j < n; j++) begin
            step();
            check("cmp_start", 32'(cmp_start), 32'd1);
            check("cmp_slot", 32'(cmp_slot), 32'(sl[j*3 +: 3]));
            step();
            check("cmp_start_pulse", 32'(cmp_start), 32'd0);
            cmp_done  = 1'b1;
            cmp_score = sc[j*16 +: 16];
            step();
            cmp_done  = 1'b0;
        end
        step();
        check("res_valid", 32'(result_valid), 32'd1);
        check("res_busy", 32'(busy), 32'd0);
        check("res_no_cmp", 32'(cmp_start), 32'd0);
        check("res_slot", 32'(result_slot), 32'(es));
        check("res_score", 32'(result_score), 32'(escore));
        check("res_nm", 32'(no_match), 32'(enm));
        step();
        check("res_valid_clr", 32'(result_valid), 32'd0);
        check("res_hold", 32'(result_score), 32'(escore));
    endtask

    initial begin
        reset_n = 1'b0;
        sample_valid = 1'b0;
        sample = 8'd0;
        train_start = 1'b0;
        train_slot = 3'd0;
        recog_start = 1'b0;
        abort = 1'b0;
        cmp_done = 1'b0;
        cmp_score = 16'd0;
        #12;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sv", 32'(slot_valid), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_res", 32'(result_score), 32'd0);
        check("rst_nm", 32'(no_match), 32'd0);
        reset_n = 1'b1;
        step();

        recog(0, 12'd0, 64'd0, 3'd0, 16'hFFFF, 1'b1);

        train(3'd1, 8'h11, 4'b0010);

        train_start = 1'b1;
        train_slot  = 3'd3;
        step();
        train_start = 1'b0;
        sample_valid = 1'b1;
        step();
        step();
        sample_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_sv", 32'(slot_valid), 32'd0);
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        train(3'd0, 8'h20, 4'b0001);
        train(3'd2, 8'h30, 4'b0101);
        recog(2, {6'd0, 3'd2, 3'd0}, {32'd0, 16'd100, 16'd300},
              3'd2, 16'd100, 1'b0);

        train(3'd3, 8'h40, 4'b1101);
        recog(3, {3'd0, 3'd3, 3'd2, 3'd0}, {16'd0, 16'd50, 16'd60, 16'd50},
              3'd0, 16'd50, 1'b0);
        recog(3, {3'd0, 3'd3, 3'd2, 3'd0},
              {16'd0, 16'd4001, 16'd5000, 16'd4001}, 3'd0, 16'd4001, 1'b1);

        train_start = 1'b1;
        train_slot  = 3'd3;
        step();
        train_start = 1'b0;
        sample_valid = 1'b1;
        step();
        step();
        sample_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_tr_state", 32'(state_dbg), 32'd0);
        check("ab_tr_sv", 32'(slot_valid), 32'b0101);
        check("ab_tr_done", 32'(train_done), 32'd0);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("ab_tr_ignored_we", 32'(mem_we), 32'd0);

        recog_start = 1'b1;
        step();
        recog_start = 1'b0;
        sample_valid = 1'b1;
        repeat (4) step();
        sample_valid = 1'b0;
        step();
        check("ab_cw_start", 32'(cmp_start), 32'd1);
        check("ab_cw_state", 32'(state_dbg), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_cw_idle", 32'(state_dbg), 32'd0);
        cmp_done  = 1'b1;
        cmp_score = 16'd1;
        step();
        cmp_done = 1'b0;
        check("ab_cw_rv0", 32'(result_valid), 32'd0);
        step();
        check("ab_cw_rv1", 32'(result_valid), 32'd0);
        check("ab_cw_hold", 32'(result_score), 32'd4001);

        train_start = 1'b1;
        recog_start = 1'b1;
        train_slot  = 3'd3;
        step();
        train_start = 1'b0;
        recog_start = 1'b0;
        check("both_state", 32'(state_dbg), 32'd1);
        recog_start = 1'b1;
        step();
        recog_start = 1'b0;
        check("cap_recog_ign", 32'(state_dbg), 32'd1);
        check("cap_recog_we", 32'(mem_we), 32'd0);
        for (int k = 0; k < 4; k++) begin
            sample_valid = 1'b1;
            sample       = 8'h50 + 8'(k);
            step();
            sample_valid = 1'b0;
            check("both_region", 32'(mem_region), 32'd3);
            check("both_idx", 32'(mem_idx), 32'(k));
        end
        check("both_done", 32'(train_done), 32'd1);
        check("both_sv", 32'(slot_valid), 32'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
